vedic_seq_mul_ctrl: RTL and testbench

Sequencing controller that computes one MUL_Size x MUL_Size unsigned product by time-sharing a single external half-width multiplier, (MUL_Size/2)x(MUL_Size/2), over four cycles. It issues the four partial products in a fixed order, captures them in registers q0..q3, and combines them through an internal vedic_adder instance (MUL_Size parameter passed through). Valid/ready handshakes are used on both the operand side and the result side, so the block drops between an operand source and a result consumer.

---
 rtl/vedic_seq_mul_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_vedic_seq_mul_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mul_ctrl.sv
// vedic_seq_mul_ctrl: computes one MUL_Size x MUL_Size unsigned product by
// time-sharing an external (MUL_Size/2)x(MUL_Size/2) multiplier over four cycles.
// The block has a valid/ready handshake on the operand side and on the result side.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake for A, B
//   mul_en/mul_a/mul_b  request to the shared multiplier
//   mul_p               same-cycle product from the shared multiplier
//   out_valid/out_ready result handshake for Q
//   busy                high whenever the controller is not idle

// vedic_adder: combines the four half-width partial products into the full product.
// Ports: q0..q3 partial products (LL, LH, HL, HH), sum full-width product.
module vedic_adder #(
  parameter int unsigned MUL_Size = 4,
  localparam int unsigned Half_Size = MUL_Size / 2,
  localparam int unsigned Mul_Output_Size = 2 * MUL_Size
) (
  input  logic [MUL_Size-1:0]        q0,
  input  logic [MUL_Size-1:0]        q1,
  input  logic [MUL_Size-1:0]        q2,
  input  logic [MUL_Size-1:0]        q3,
  output logic [Mul_Output_Size-1:0] sum
);

  // Cross terms share the Half_Size weight; their carry is kept by widening first.
  always_comb begin
    sum = Mul_Output_Size'(q0)
        + ((Mul_Output_Size'(q1) + Mul_Output_Size'(q2)) << Half_Size)
        + (Mul_Output_Size'(q3) << MUL_Size);
  end

endmodule

module vedic_seq_mul_ctrl #(
  parameter int unsigned MUL_Size = 4,
  localparam int unsigned Half_Size = MUL_Size / 2,
  localparam int unsigned Mul_Output_Size = 2 * MUL_Size
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MUL_Size-1:0]        A,
  input  logic [MUL_Size-1:0]        B,
  output logic                       mul_en,
  output logic [Half_Size-1:0]       mul_a,
  output logic [Half_Size-1:0]       mul_b,
  input  logic [MUL_Size-1:0]        mul_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Mul_Output_Size-1:0] Q,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            step_q, step_d;
  logic [MUL_Size-1:0]   a_q, a_d, b_q, b_d;
  logic [MUL_Size-1:0]   q0_q, q0_d, q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  mul_en_q, mul_en_d;
  logic [Half_Size-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                  busy_q, busy_d;

  logic [Half_Size-1:0]  al, ah, bl, bh;

  assign al = a_q[Half_Size-1:0];
  assign ah = a_q[MUL_Size-1:Half_Size];
  assign bl = b_q[Half_Size-1:0];
  assign bh = b_q[MUL_Size-1:Half_Size];

  // Next-state logic. mul_a/mul_b are registered, so each MUL cycle preloads
  // the operand pair for the following step (the accept edge preloads step 0).
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    q0_d        = q0_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    q3_d        = q3_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    mul_en_d    = mul_en_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = A;
          b_d        = B;
          step_d     = 2'd0;
          state_d    = S_MUL;
          in_ready_d = 1'b0;
          mul_en_d   = 1'b1;
          mul_a_d    = A[Half_Size-1:0];
          mul_b_d    = B[Half_Size-1:0];
          busy_d     = 1'b1;
        end
      end
      S_MUL: begin
        step_d = step_q + 2'd1;
        unique case (step_q)
          2'd0: begin
            q0_d    = mul_p;
            mul_a_d = al;
            mul_b_d = bh;
          end
          2'd1: begin
            q1_d    = mul_p;
            mul_a_d = ah;
            mul_b_d = bl;
          end
          2'd2: begin
            q2_d    = mul_p;
            mul_a_d = ah;
            mul_b_d = bh;
          end
          default: begin
            q3_d        = mul_p;
            mul_a_d     = '0;
            mul_b_d     = '0;
            mul_en_d    = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        // in_ready stays low here, so the result edge can never also accept.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        mul_en_d    = 1'b0;
        mul_a_d     = '0;
        mul_b_d     = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q3_q        <= q3_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;

  vedic_adder #(.MUL_Size(MUL_Size)) u_adder (
    .q0  (q0_q),
    .q1  (q1_q),
    .q2  (q2_q),
    .q3  (q3_q),
    .sum (Q)
  );

endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Testbench for vedic_seq_mul_ctrl at MUL_Size=4: directed vector table,
// hold/reset corner sequences and a full (A,B) sweep against A*B.
module tb_vedic_seq_mul_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned H = 2;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B;
  logic         mul_en;
  logic [H-1:0] mul_a, mul_b;
  logic [N-1:0] mul_p;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Q;
  logic         busy;

  logic [N-1:0] junk;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) junk <= N'($urandom);

  // Shared multiplier; returns garbage whenever it is not enabled.
  assign mul_p = mul_en ? (N'(mul_a) * N'(mul_b)) : junk;

  vedic_seq_mul_ctrl #(.MUL_Size(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] q;
    int           hold;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One full transaction: accept, four multiplier steps, optional backpressure, result.
  task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W-1:0] exp_q, input int hold, output int acc_cyc);
    int waited;
    logic [H-1:0] xa, xb;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    check("mul_en_idle", 32'(mul_en), 32'd0);
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk); #1;
    acc_cyc = cyc;
    for (int s = 0; s < 4; s++) begin
      xa = H'((s >= 2) ? (a / 4) : (a % 4));
      xb = H'((s % 2 == 1) ? (b / 4) : (b % 4));
      check("mul_en_step", 32'(mul_en), 32'd1);
      check("mul_a_step", 32'(mul_a), 32'(xa));
      check("mul_b_step", 32'(mul_b), 32'(xb));
      check("in_ready_mul", 32'(in_ready), 32'd0);
      check("out_valid_mul", 32'(out_valid), 32'd0);
      check("busy_mul", 32'(busy), 32'd1);
      // Operand noise while busy must be ignored.
      in_valid = 1'($urandom);
      A = N'($urandom);
      B = N'($urandom);
      @(posedge clk); #1;
    end
    check("out_valid_done", 32'(out_valid), 32'd1);
    check("q_done", 32'(Q), 32'(exp_q));
    check("mul_en_done", 32'(mul_en), 32'd0);
    check("mul_a_done", 32'(mul_a), 32'd0);
    check("mul_b_done", 32'(mul_b), 32'd0);
    check("in_ready_done", 32'(in_ready), 32'd0);
    check("busy_done", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("q_hold", 32'(Q), 32'(exp_q));
      check("in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, aa, bb;

    vecs[0] = '{a: 4'hF, b: 4'hF, q: 8'hE1, hold: 0};
    vecs[1] = '{a: 4'hB, b: 4'h6, q: 8'h42, hold: 0};
    vecs[2] = '{a: 4'h0, b: 4'h9, q: 8'h00, hold: 0};
    vecs[3] = '{a: 4'h1, b: 4'h1, q: 8'h01, hold: 0};
    vecs[4] = '{a: 4'h7, b: 4'hD, q: 8'h5B, hold: 3};
    vecs[5] = '{a: 4'h9, b: 4'h9, q: 8'h51, hold: 0};
    vecs[6] = '{a: 4'h2, b: 4'hE, q: 8'h1C, hold: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(Q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, back to back; accept spacing is 6 plus any hold cycles.
    prev_acc = 0;
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].hold, acc);
      if (i > 0) check("accept_interval", 32'(acc - prev_acc), 32'(6 + vecs[i-1].hold));
      prev_acc = acc;
    end

    // Reset asserted mid-cycle during step 2 aborts the transaction.
    in_valid = 1'b1;
    A = 4'hC;
    B = 4'hA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_step2_a", 32'(mul_a), 32'd3);
    check("abort_step2_b", 32'(mul_b), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_mul_en", 32'(mul_en), 32'd0);
    check("abort_mul_a", 32'(mul_a), 32'd0);
    check("abort_mul_b", 32'(mul_b), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(Q), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_hold_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end
    run_txn(4'h5, 4'h3, 8'h0F, 0, acc);

    // Full sweep with random backpressure against a plain A*B reference.
    for (aa = 0; aa < 16; aa++) begin
      for (bb = 0; bb < 16; bb++) begin
        run_txn(N'(aa), N'(bb), W'(aa * bb), int'($urandom_range(0, 3)), acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
